// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, 4x4 keymap table and scanner FSM state encoding.
package keypad_pkg;
  localparam logic [4:0] KEY_PLUS  = 5'd10;
  localparam logic [4:0] KEY_MINUS = 5'd11;
  localparam logic [4:0] KEY_MUL   = 5'd12;
  localparam logic [4:0] KEY_DIV   = 5'd13;
  localparam logic [4:0] KEY_EQ    = 5'd14;
  localparam logic [4:0] KEY_CLEAR = 5'd15;
  localparam logic [4:0] KEY_NONE  = 5'h1F;
  // indexed by {row, col}
  localparam logic [4:0] KEYMAP [16] = '{
    5'd1,      5'd2, 5'd3,   KEY_PLUS,
    5'd4,      5'd5, 5'd6,   KEY_MINUS,
    5'd7,      5'd8, 5'd9,   KEY_MUL,
    KEY_CLEAR, 5'd0, KEY_EQ, KEY_DIV
  };
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
endpackage

// File: rtl/keypad_sync_2ff.sv
// keypad_sync_2ff: 4-bit two-flop synchronizer for the asynchronous keypad rows, resets to all-ones.
module keypad_sync_2ff (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= '1;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scanner with debounce, one key code pulse per press.
// Define KEYPAD_REPEAT_EN to enable auto-repeat pulses while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_DELAY = 500
  , parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] button,
  output logic       validPress
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  state_t state, state_d;
  logic [DW-1:0] div_cnt;
  logic [1:0] col, col_d, row, row_d, low_idx;
  logic [CW-1:0] cnt, cnt_d, rel_cnt, rel_d;
  logic [4:0] button_d;
  logic valid_d, sample, row_low;
  logic [3:0] rows;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rep_cnt, rep_d;
`endif
  keypad_sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(row_n), .q(rows));
  assign sample  = div_cnt == DW'(SCAN_DIV - 1);
  assign row_low = !rows[row];
  assign low_idx = !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
  assign col_n   = ~(4'b0001 << col);
  always_comb begin
    state_d  = state;
    col_d    = col;
    row_d    = row;
    cnt_d    = cnt;
    rel_d    = rel_cnt;
    button_d = button;
    valid_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d    = rep_cnt;
`endif
    if (sample) begin
      case (state)
        SCAN:
          if (&rows) col_d = col + 2'd1;
          else begin
            row_d   = low_idx;
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end
        DEBOUNCE:
          if (!row_low) begin
            state_d = SCAN;
            col_d   = col + 2'd1;
            cnt_d   = '0;
          end else if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
            state_d  = HELD;
            button_d = KEYMAP[{row, col}];
            valid_d  = 1'b1;
            cnt_d    = '0;
            rel_d    = '0;
          end else cnt_d = cnt + 1'b1;
        HELD:
          if (row_low) begin
            rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
            // after the first repeat, rewinding keeps later repeats REPEAT_RATE samples apart
            if (rep_cnt == RW'(REPEAT_DELAY - 1)) begin
              valid_d = 1'b1;
              rep_d   = RW'(REPEAT_DELAY - REPEAT_RATE);
            end else rep_d = rep_cnt + 1'b1;
`endif
          end else if (rel_cnt == CW'(DEBOUNCE_CNT - 1)) begin
            state_d = SCAN;
            col_d   = col + 2'd1;
            rel_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else rel_d = rel_cnt + 1'b1;
        default: state_d = SCAN;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= SCAN;
      div_cnt    <= '0;
      col        <= '0;
      row        <= '0;
      cnt        <= '0;
      rel_cnt    <= '0;
      button     <= KEY_NONE;
      validPress <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      state      <= state_d;
      div_cnt    <= sample ? '0 : div_cnt + 1'b1;
      col        <= col_d;
      row        <= row_d;
      cnt        <= cnt_d;
      rel_cnt    <= rel_d;
      button     <= button_d;
      validPress <= valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= rep_d;
`endif
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model with a scoreboard of expected key codes per pulse.
module tb_keypad_scanner;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] row_n, col_n;
  logic [4:0] button;
  logic validPress, prev_vp = 1'b0;
  logic [15:0] keys = '0;
  logic [4:0] exp_q [$];
  logic [3:0] col_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int n_checks = 0, n_fail = 0, cyc_cnt = 0, npulse = 0, pulse_cyc = 0;
  int base, t0;
`ifdef KEYPAD_REPEAT_EN
  localparam int N_REP = 7, LAST_REP = 112;
`else
  localparam int N_REP = 1, LAST_REP = 12;
`endif
  keypad_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_CNT(3)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_DELAY(10), .REPEAT_RATE(3)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n),
    .col_n(col_n), .button(button), .validPress(validPress)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  // a pressed key pulls its row low only while its column is driven
  always_comb for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask
  always @(negedge clk) begin
    if (validPress) begin
      npulse++;
      pulse_cyc = cyc_cnt;
      chk("pulse_gap", {31'd0, prev_vp}, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: button=%0d with no press pending (cycle %0d)", button, cyc_cnt);
      end else chk("pulse_button", {27'd0, button}, {27'd0, exp_q.pop_front()});
    end
    prev_vp = validPress;
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic wait_col(input logic [3:0] target);
    logic [3:0] prev = col_n;
    logic hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      cyc(1);
      hit = col_n == target && prev != target;
      prev = col_n;
    end
    chk("wait_col", {31'd0, hit}, 1);
  endtask
  task automatic wait_pulse(input int bound);
    int start = npulse;
    for (int i = 0; i < bound && npulse == start; i++) cyc(1);
    chk("pulse_seen", {31'd0, npulse != start}, 1);
  endtask
  initial begin
    int idx [3] = '{14, 12, 3};
    int code [3] = '{14, 15, 10};
    cyc(3);
    chk("rst_col", col_n, 4'b1110);
    chk("rst_button", button, 5'h1F);
    chk("rst_valid", validPress, 0);
    rst_n = 1'b1;
    chk("scan_col_0", col_n, col_seq[0]);
    for (int k = 1; k < 20; k++) begin
      cyc(1);
      chk("scan_col", col_n, col_seq[(k / 4) % 4]);
    end
    // key '6' pressed right after column 2 is selected
    wait_col(4'b1011);
    t0 = cyc_cnt;
    base = npulse;
    keys[6] = 1'b1;
    exp_q.push_back(5'd6);
    cyc(12);
    chk("t2_latency", pulse_cyc, t0 + 12);
    cyc(1);
    chk("t2_pulse_width", validPress, 0);
    cyc(40);
    chk("t2_col_held", col_n, 4'b1011);
    chk("t2_button", button, 5'd6);
    keys[6] = 1'b0;
    wait_col(4'b0111);
    chk("t2_button_kept", button, 5'd6);
    chk("t2_one_pulse", npulse - base, 1);
    // bounce: low 2 samples, high 1, low again
    wait_col(4'b1011);
    base = npulse;
    keys[6] = 1'b1;
    cyc(8);
    keys[6] = 1'b0;
    cyc(4);
    chk("t3_next_col", col_n, 4'b0111);
    keys[6] = 1'b1;
    cyc(8);
    keys[6] = 1'b0;
    cyc(24);
    chk("t3_no_pulse", npulse - base, 0);
    chk("t3_button", button, 5'd6);
    // long hold with a bouncy release
    base = npulse;
    keys[6] = 1'b1;
    exp_q.push_back(5'd6);
    cyc(1000);
    chk("t4_col_held", col_n, 4'b1011);
    keys[6] = 1'b0; cyc(5);
    keys[6] = 1'b1; cyc(5);
    keys[6] = 1'b0; cyc(5);
    keys[6] = 1'b1; cyc(3);
    keys[6] = 1'b0;
    cyc(40);
    chk("t4_one_pulse", npulse - base, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(5'(code[i]));
      keys[idx[i]] = 1'b1;
      wait_pulse(100);
      chk("t4_code", button, code[i]);
      cyc(10);
      keys[idx[i]] = 1'b0;
      cyc(40);
    end
    // reset while debouncing '6'
    wait_col(4'b1011);
    keys[6] = 1'b1;
    cyc(6);
    base = npulse;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_col", col_n, 4'b1110);
    chk("t5_rst_button", button, 5'h1F);
    chk("t5_rst_valid", validPress, 0);
    cyc(3);
    chk("t5_no_pulse_in_rst", npulse - base, 0);
    rst_n = 1'b1;
    t0 = cyc_cnt;
    exp_q.push_back(5'd6);
    cyc(20);
    chk("t5_latency", pulse_cyc, t0 + 20);
    chk("t5_one_pulse", npulse - base, 1);
    keys[6] = 1'b0;
    cyc(40);
    // hold '5' for 30 samples
    wait_col(4'b1101);
    t0 = cyc_cnt;
    base = npulse;
    keys[5] = 1'b1;
    repeat (N_REP) exp_q.push_back(5'd5);
    cyc(118);
    keys[5] = 1'b0;
    cyc(40);
    chk("t6_pulses", npulse - base, N_REP);
    chk("t6_last_pulse", pulse_cyc, t0 + LAST_REP);
    chk("t6_button", button, 5'd5);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
